// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer master sequencer: slave register
// map, control register bit positions and the sequencer state encoding.
package timer_pkg;

    // Timer slave word addresses
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    // Control register bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR,
        WR_STOP,
        SNAP_WR,
        RD_L,
        RD_H,
        CAP
    } state_t;

    // Assemble a control register write value from its individual bits
    function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                              input logic start, input logic stop);
        logic [15:0] w;
        w             = '0;
        w[CTRL_ITO]   = ito;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = start;
        w[CTRL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_bus_drv.sv
// Registered single-cycle Avalon-MM access generator. A request presented in
// one cycle becomes a one-cycle chipselect strobe in the next; with no request
// the bus is parked at chipselect=0, read, address/data zero.
module timer_bus_drv
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata
);

    // Register the requested access onto the bus pins for exactly one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= '0;
            m_writedata  <= '0;
        end else if (req) begin
            m_chipselect <= 1'b1;
            m_write_n    <= ~wr;
            m_address    <= addr;
            m_writedata  <= wr ? wdata : 16'h0000;
        end else begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= '0;
            m_writedata  <= '0;
        end
    end

endmodule

// File: rtl/timer_master_seq.sv
// CPU-less master for the interval timer slave: programs period and control,
// services timeouts (clear + tick count), takes counter snapshots and stops
// the timer on request. Bus accesses are generated from the next state so the
// registered bus pins line up with the state that owns the access.
module timer_master_seq
    import timer_pkg::*;
#(
    parameter int TICK_W         = 16,
    parameter bit AUTO_CLEAR_CNT = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    input  logic              irq,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic              cmd_err
);

    state_t      state, next_state;
    logic [31:0] period_q;
    logic        cont_q;
    logic        stop_pend, snap_pend;
    logic        start_ok;

    logic        bus_req, bus_wr;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;

    assign start_ok = (state == IDLE) && cmd_start && (cmd_period != 32'd0);
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state decode and bus request for the access owned by the next state
    always_comb begin
        next_state = state;
        bus_req    = 1'b0;
        bus_wr     = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;

        unique case (state)
            IDLE:    if (start_ok) next_state = WR_PL;
            WR_PL:   next_state = WR_PH;
            WR_PH:   next_state = WR_CTRL;
            WR_CTRL: next_state = RUN;
            RUN: begin
                if (cmd_stop || stop_pend)      next_state = WR_STOP;
                else if (irq)                   next_state = CLR;
                else if (cmd_snap || snap_pend) next_state = SNAP_WR;
            end
            CLR:     next_state = cont_q ? RUN : IDLE;
            WR_STOP: next_state = IDLE;
            SNAP_WR: next_state = RD_L;
            RD_L:    next_state = RD_H;
            RD_H:    next_state = CAP;
            CAP:     next_state = RUN;
            default: next_state = IDLE;
        endcase

        unique case (next_state)
            WR_PL: begin
                // Period register is not loaded yet on this edge; use the command
                bus_req = 1'b1; bus_wr = 1'b1;
                bus_addr = ADDR_PERIOD_L; bus_wdata = cmd_period[15:0];
            end
            WR_PH: begin
                bus_req = 1'b1; bus_wr = 1'b1;
                bus_addr = ADDR_PERIOD_H; bus_wdata = period_q[31:16];
            end
            WR_CTRL: begin
                bus_req = 1'b1; bus_wr = 1'b1;
                bus_addr = ADDR_CONTROL; bus_wdata = ctrl_word(1'b1, cont_q, 1'b1, 1'b0);
            end
            CLR: begin
                bus_req = 1'b1; bus_wr = 1'b1;
                bus_addr = ADDR_STATUS; bus_wdata = 16'h0000;
            end
            WR_STOP: begin
                bus_req = 1'b1; bus_wr = 1'b1;
                bus_addr = ADDR_CONTROL; bus_wdata = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
            end
            SNAP_WR: begin
                bus_req = 1'b1; bus_wr = 1'b1;
                bus_addr = ADDR_SNAP_L; bus_wdata = 16'h0000;
            end
            RD_L: begin
                bus_req = 1'b1; bus_addr = ADDR_SNAP_L;
            end
            RD_H: begin
                bus_req = 1'b1; bus_addr = ADDR_SNAP_H;
            end
            default: ;
        endcase
    end

    // Latch the programmed period and mode on an accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
            cont_q   <= 1'b0;
        end else if (start_ok) begin
            period_q <= cmd_period;
            cont_q   <= cmd_continuous;
        end
    end

    // Remember stop/snap requests that arrive while a sequence is in flight;
    // a snap that loses to a timeout in RUN is also held over
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stop_pend <= 1'b0;
            snap_pend <= 1'b0;
        end else if (next_state == IDLE) begin
            stop_pend <= 1'b0;
            snap_pend <= 1'b0;
        end else begin
            if (state == RUN && next_state == WR_STOP) stop_pend <= 1'b0;
            else if (cmd_stop && state != IDLE)        stop_pend <= 1'b1;
            if (state == RUN && next_state == SNAP_WR) snap_pend <= 1'b0;
            else if (cmd_snap && state != IDLE)        snap_pend <= 1'b1;
        end
    end

    // Running flag, timeout ticks and start-rejection pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running    <= 1'b0;
            tick       <= 1'b0;
            tick_count <= '0;
            cmd_err    <= 1'b0;
        end else begin
            if (next_state == IDLE)  running <= 1'b0;
            else if (state == WR_CTRL) running <= 1'b1;
            tick    <= (next_state == CLR);
            cmd_err <= (state == IDLE) && cmd_start && (cmd_period == 32'd0);
            if (next_state == CLR)
                tick_count <= tick_count + 1'b1;
            else if (start_ok && AUTO_CLEAR_CNT)
                tick_count <= '0;
        end
    end

    // Snapshot capture: low half arrives during RD_H, high half during CAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_value <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= 1'b0;
            if (state == RD_H) snap_value[15:0] <= m_readdata;
            if (state == CAP) begin
                snap_value[31:16] <= m_readdata;
                snap_valid        <= 1'b1;
            end
        end
    end

    timer_bus_drv u_bus_drv (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (bus_req),
        .wr           (bus_wr),
        .addr         (bus_addr),
        .wdata        (bus_wdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata)
    );

endmodule
